// File: rtl/fetch_buffer_if.sv
// Fetch-stage bundle: PC control, instruction-memory request/response and decode handoff.
// The master modport is the fetch buffer's view; slave is the surrounding PC/memory/decode side.
interface fetch_buffer_if;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        stall_o;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    input  pc_i, flush_i, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    output stall_o, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output pc_i, flush_i, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    input  stall_o, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues in-order imem reads at the PC, tags responses with their PC,
// queues {pc, instr} for decode, and discards wrong-path responses after a redirect.
module fetch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_buffer_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   tag_mem   [MAX_OUT];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [TW-1:0] tag_rd, tag_wr;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] out_cnt, drop_cnt;

  logic credit_ok, room_ok, issue, rsp_ok, push, pop;

  always_comb begin
    credit_ok          = (32'(fifo_count) + 32'(out_cnt)) < DEPTH;
    room_ok            = 32'(out_cnt) < MAX_OUT;
    bus.imem_req_valid = !rst && !bus.flush_i && credit_ok && room_ok;
    bus.imem_req_addr  = {bus.pc_i[31:2], 2'b00};
    issue              = bus.imem_req_valid && bus.imem_req_ready;
    bus.stall_o        = !rst && !bus.flush_i && !issue;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok             = bus.imem_rsp_valid && (out_cnt != '0);
    push               = rsp_ok && (drop_cnt == '0) && !bus.flush_i;
    bus.dec_valid      = (fifo_count != '0) && !rst;
    pop                = bus.dec_valid && bus.dec_ready && !bus.flush_i;
    bus.dec_instr      = (fifo_count != '0) ? instr_mem[rd_ptr] : '0;
    bus.dec_pc         = (fifo_count != '0) ? pc_mem[rd_ptr]    : '0;
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (!rst && issue) tag_mem[tag_wr] <= bus.pc_i;
    if (!rst && push) begin
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag_rd     <= '0;
      tag_wr     <= '0;
      fifo_count <= '0;
      out_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (issue) tag_wr <= (tag_wr == TW'(MAX_OUT - 1)) ? '0 : tag_wr + 1'b1;
      if (rsp_ok) tag_rd <= (tag_rd == TW'(MAX_OUT - 1)) ? '0 : tag_rd + 1'b1;
      out_cnt <= out_cnt + OW'(issue) - OW'(rsp_ok);

      // Everything still in flight after a redirect is wrong-path; the flush-cycle response is dropped here too.
      if (bus.flush_i) begin
        drop_cnt   <= out_cnt - OW'(rsp_ok);
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.imem_rsp_valid) assert (out_cnt != '0);
  end

endmodule
